// File: rtl/flex_stp_deser.sv
// flex_stp_deser: multi-lane serial-to-parallel word deserializer.
// Frames NUM_BITS-wide words from LANES bits per enabled clock and hands
// each completed word to a one-deep valid/ready holding register with
// sticky overflow detection.
// Optional build macro FLEX_STP_DESER_PARITY_EN adds a trailing even-parity
// beat per word and drives out_err; without it out_err is constant 0.
module flex_stp_deser #(
   parameter int NUM_BITS  = 8,
   parameter int LANES     = 1,
   parameter int SHIFT_MSB = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                shift_enable,
   input  logic [LANES-1:0]    serial_in,
   input  logic                clear,
   output logic [NUM_BITS-1:0] parallel_out,
   output logic                out_valid,
   input  logic                out_ready,
   output logic                busy,
   output logic                overflow,
   output logic                out_err
);

   localparam int BEATS = NUM_BITS / LANES;
   localparam int CNT_W = $clog2(BEATS + 1);
`ifdef FLEX_STP_DESER_PARITY_EN
   // The parity beat follows the last data beat, so the count runs one further.
   localparam int LAST_BEAT = BEATS;
`else
   localparam int LAST_BEAT = BEATS - 1;
`endif
   localparam logic [CNT_W-1:0]    LAST_CNT = CNT_W'(LAST_BEAT);
   localparam logic [CNT_W-1:0]    CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1);
   localparam logic [NUM_BITS-1:0] ONES     = {NUM_BITS{1'b1}};

   logic [NUM_BITS-1:0] sr_q, sr_d;
   logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;
   logic [NUM_BITS-1:0] parallel_out_q, parallel_out_d;
   logic                out_valid_q, out_valid_d;
   logic                overflow_q, overflow_d;
   logic [NUM_BITS-1:0] sr_shift_s;
   logic [NUM_BITS-1:0] word_s;
   logic                last_beat_s;
   logic                can_load_s;

`ifdef FLEX_STP_DESER_PARITY_EN
   logic out_err_q, out_err_d;

   // Even parity: the data bits XOR the received parity bit must be zero.
   function automatic logic parity_mismatch(input logic [NUM_BITS-1:0] word,
                                            input logic                par_bit);
      return (^word) ^ par_bit;
   endfunction
`else
   logic unused_sr_s;
   // Bits shifted out on the final beat never reach a word.
   assign unused_sr_s = ^sr_q;
`endif

   // Shift register value after accepting this cycle's lanes.
   always_comb begin
      if (SHIFT_MSB != 32'sd0) begin
         sr_shift_s = {sr_q[NUM_BITS-LANES-1:0], serial_in};
      end else begin
         sr_shift_s = {serial_in, sr_q[NUM_BITS-1:LANES]};
      end
   end

   // Completion detection and the word that a completion would deliver.
   always_comb begin
      last_beat_s = shift_enable && (beat_cnt_q == LAST_CNT);
      can_load_s  = !out_valid_q || out_ready;
`ifdef FLEX_STP_DESER_PARITY_EN
      word_s      = sr_q;
`else
      word_s      = sr_shift_s;
`endif
   end

   // Next-state: clear aborts the partial word, else beat/handshake updates.
   always_comb begin
      sr_d           = sr_q;
      beat_cnt_d     = beat_cnt_q;
      parallel_out_d = parallel_out_q;
      out_valid_d    = out_valid_q;
      overflow_d     = overflow_q;
`ifdef FLEX_STP_DESER_PARITY_EN
      out_err_d      = out_err_q;
`endif
      if (clear) begin
         beat_cnt_d = CNT_ZERO;
         sr_d       = ONES;
         overflow_d = 1'b0;
      end else begin
         if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
         end else begin
            out_valid_d = out_valid_q;
         end
         if (last_beat_s) begin
            sr_d       = ONES;
            beat_cnt_d = CNT_ZERO;
            if (can_load_s) begin
               parallel_out_d = word_s;
               out_valid_d    = 1'b1;
`ifdef FLEX_STP_DESER_PARITY_EN
               out_err_d      = parity_mismatch(sr_q, serial_in[0]);
`endif
            end else begin
               overflow_d = 1'b1;
            end
         end else if (shift_enable) begin
            sr_d       = sr_shift_s;
            beat_cnt_d = beat_cnt_q + CNT_ONE;
         end else begin
            sr_d       = sr_q;
            beat_cnt_d = beat_cnt_q;
         end
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         sr_q           <= ONES;
         beat_cnt_q     <= CNT_ZERO;
         parallel_out_q <= ONES;
         out_valid_q    <= 1'b0;
         overflow_q     <= 1'b0;
      end else begin
         sr_q           <= sr_d;
         beat_cnt_q     <= beat_cnt_d;
         parallel_out_q <= parallel_out_d;
         out_valid_q    <= out_valid_d;
         overflow_q     <= overflow_d;
      end
   end

`ifdef FLEX_STP_DESER_PARITY_EN
   // Parity error flag travels with the word in the holding register.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_err_q <= 1'b0;
      end else begin
         out_err_q <= out_err_d;
      end
   end

   assign out_err = out_err_q;
`else
   assign out_err = 1'b0;
`endif

   assign parallel_out = parallel_out_q;
   assign out_valid    = out_valid_q;
   assign overflow     = overflow_q;
   assign busy         = (beat_cnt_q != CNT_ZERO);

endmodule

// File: tb/tb_flex_stp_deser.sv
// Self-checking bench for flex_stp_deser: three configurations
// (8b/1 lane MSB-first, 8b/1 lane LSB-first, 16b/4 lanes MSB-first), directed
// steps followed by randomized traffic, compared against a bit-placement model.
module tb_flex_stp_deser;

`ifdef FLEX_STP_DESER_PARITY_EN
   localparam bit PAR = 1'b1;
`else
   localparam bit PAR = 1'b0;
`endif
   localparam int NB [3] = '{8, 8, 16};
   localparam int LN [3] = '{1, 1, 4};
   localparam int MS [3] = '{1, 0, 1};

   logic        clk = 1'b0;
   logic        rst;
   logic        se  [3];
   logic        clr [3];
   logic        rdy [3];
   logic [3:0]  sin [3];
   logic [7:0]  po0, po1;
   logic [15:0] po2;
   logic [15:0] pw  [3];
   logic        val [3];
   logic        bsy [3];
   logic        ovf [3];
   logic        err [3];

   int checks   = 0;
   int failures = 0;

   // reference model state
   logic [15:0] m_acc [3];
   logic [15:0] m_out [3];
   int          m_nb  [3];
   logic        m_val [3];
   logic        m_ovf [3];
   logic        m_err [3];

   always #5 clk = ~clk;

   flex_stp_deser #(.NUM_BITS(8), .LANES(1), .SHIFT_MSB(1)) d0 (
      .clk(clk), .rst(rst), .shift_enable(se[0]), .serial_in(sin[0][0:0]),
      .clear(clr[0]), .parallel_out(po0), .out_valid(val[0]), .out_ready(rdy[0]),
      .busy(bsy[0]), .overflow(ovf[0]), .out_err(err[0]));

   flex_stp_deser #(.NUM_BITS(8), .LANES(1), .SHIFT_MSB(0)) d1 (
      .clk(clk), .rst(rst), .shift_enable(se[1]), .serial_in(sin[1][0:0]),
      .clear(clr[1]), .parallel_out(po1), .out_valid(val[1]), .out_ready(rdy[1]),
      .busy(bsy[1]), .overflow(ovf[1]), .out_err(err[1]));

   flex_stp_deser #(.NUM_BITS(16), .LANES(4), .SHIFT_MSB(1)) d2 (
      .clk(clk), .rst(rst), .shift_enable(se[2]), .serial_in(sin[2]),
      .clear(clr[2]), .parallel_out(po2), .out_valid(val[2]), .out_ready(rdy[2]),
      .busy(bsy[2]), .overflow(ovf[2]), .out_err(err[2]));

   assign pw[0] = {8'h00, po0};
   assign pw[1] = {8'h00, po1};
   assign pw[2] = po2;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset(input int i);
      m_acc[i] = 16'h0000;
      m_out[i] = 16'hFFFF >> (16 - NB[i]);
      m_nb[i]  = 0;
      m_val[i] = 1'b0;
      m_ovf[i] = 1'b0;
      m_err[i] = 1'b0;
   endtask

   // Model: the k-th arriving bit lands at bit N-1-k (MSB-first) or k (LSB-first).
   task automatic model_step(input int i);
      logic        complete;
      logic [15:0] word;
      logic        perr;
      logic        nval;
      int          lane;
      complete = 1'b0;
      word     = 16'h0000;
      perr     = 1'b0;
      if (rst) begin
         model_reset(i);
         return;
      end
      if (clr[i]) begin
         m_nb[i]  = 0;
         m_acc[i] = 16'h0000;
         m_ovf[i] = 1'b0;
         return;
      end
      if (se[i]) begin
         if (PAR && m_nb[i] == NB[i]) begin
            complete = 1'b1;
            word     = m_acc[i];
            perr     = (^m_acc[i]) ^ sin[i][0];
         end else begin
            for (int j = 0; j < LN[i]; j++) begin
               lane = (MS[i] != 0) ? (LN[i] - 1 - j) : j;
               if (MS[i] != 0) m_acc[i][NB[i] - 1 - m_nb[i]] = sin[i][lane];
               else            m_acc[i][m_nb[i]] = sin[i][lane];
               m_nb[i]++;
            end
            if (!PAR && m_nb[i] == NB[i]) begin
               complete = 1'b1;
               word     = m_acc[i];
            end
         end
         if (complete) begin
            m_nb[i]  = 0;
            m_acc[i] = 16'h0000;
         end
      end
      nval = m_val[i] && !rdy[i];
      if (complete) begin
         if (!m_val[i] || rdy[i]) begin
            m_out[i] = word;
            m_err[i] = perr;
            nval     = 1'b1;
         end else begin
            m_ovf[i] = 1'b1;
         end
      end
      m_val[i] = nval;
   endtask

   task automatic check_all();
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("d%0d_parallel_out", i), pw[i], m_out[i]);
         chk($sformatf("d%0d_out_valid", i), {15'd0, val[i]}, {15'd0, m_val[i]});
         chk($sformatf("d%0d_busy", i), {15'd0, bsy[i]}, {15'd0, (m_nb[i] != 0)});
         chk($sformatf("d%0d_overflow", i), {15'd0, ovf[i]}, {15'd0, m_ovf[i]});
         chk($sformatf("d%0d_out_err", i), {15'd0, err[i]}, {15'd0, m_err[i]});
      end
   endtask

   task automatic tick();
      for (int i = 0; i < 3; i++) model_step(i);
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic idle();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         se[i]  = 1'b0;
         clr[i] = 1'b0;
      end
   endtask

   task automatic beat(input int i, input logic [3:0] v);
      idle();
      se[i]  = 1'b1;
      sin[i] = v;
      tick();
      se[i]  = 1'b0;
   endtask

   // seq[7] is sent first
   task automatic send_bits(input int i, input logic [7:0] seq);
      for (int k = 7; k >= 0; k--) beat(i, {3'b000, seq[k]});
   endtask

   initial begin
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         se[i] = 1'b0; clr[i] = 1'b0; rdy[i] = 1'b0; sin[i] = 4'h0;
         model_reset(i);
      end
      tick();
      tick();
      chk("reset_po0", pw[0], 16'h00FF);
      chk("reset_po2", pw[2], 16'hFFFF);
      chk("reset_valid", {15'd0, val[0]}, 16'h0000);
      idle();

`ifndef FLEX_STP_DESER_PARITY_EN
      // MSB-first A5, busy through beats 1..7, valid exactly one cycle
      rdy[0] = 1'b1;
      for (int k = 7; k >= 0; k--) begin
         logic [7:0] s;
         s = 8'hA5;
         beat(0, {3'b000, s[k]});
         chk("a5_busy", {15'd0, bsy[0]}, {15'd0, (k != 0)});
      end
      chk("a5_msb_word", pw[0], 16'h00A5);
      chk("a5_valid", {15'd0, val[0]}, 16'h0001);
      idle(); tick();
      chk("a5_valid_one_cycle", {15'd0, val[0]}, 16'h0000);

      // LSB-first palindrome and 03
      rdy[1] = 1'b1;
      send_bits(1, 8'b10100101);
      chk("lsb_a5", pw[1], 16'h00A5);
      send_bits(1, 8'b11000000);
      chk("lsb_03", pw[1], 16'h0003);

      // four-lane DEAD, then with idle gaps
      rdy[2] = 1'b1;
      beat(2, 4'hD); beat(2, 4'hE); beat(2, 4'hA); beat(2, 4'hD);
      chk("dead", pw[2], 16'hDEAD);
      chk("dead_valid", {15'd0, val[2]}, 16'h0001);
      beat(2, 4'hD); idle(); tick(); tick();
      beat(2, 4'hE); idle(); tick(); tick();
      beat(2, 4'hA); idle(); tick(); tick();
      chk("dead_gap_busy", {15'd0, bsy[2]}, 16'h0001);
      beat(2, 4'hD);
      chk("dead_gaps", pw[2], 16'hDEAD);

      // overflow, clear, completion with same-cycle consume
      rdy[0] = 1'b0;
      send_bits(0, 8'h11);
      send_bits(0, 8'h22);
      chk("ovf_hold_word", pw[0], 16'h0011);
      chk("ovf_set", {15'd0, ovf[0]}, 16'h0001);
      idle(); clr[0] = 1'b1; tick(); clr[0] = 1'b0;
      chk("clear_ovf", {15'd0, ovf[0]}, 16'h0000);
      chk("clear_keeps_valid", {15'd0, val[0]}, 16'h0001);
      for (int k = 7; k >= 0; k--) begin
         logic [7:0] s;
         s = 8'h3C;
         rdy[0] = (k == 0);
         beat(0, {3'b000, s[k]});
      end
      chk("swap_word", pw[0], 16'h003C);
      chk("swap_valid", {15'd0, val[0]}, 16'h0001);
      chk("swap_no_ovf", {15'd0, ovf[0]}, 16'h0000);
      rdy[0] = 1'b1; idle(); tick();

      // clear with coincident shift, then clean word, then reset mid-word
      beat(0, 4'h1); beat(0, 4'h0); beat(0, 4'h1);
      idle(); clr[0] = 1'b1; se[0] = 1'b1; sin[0] = 4'h1; tick(); idle();
      chk("clear_busy", {15'd0, bsy[0]}, 16'h0000);
      send_bits(0, 8'h5A);
      chk("clean_word", pw[0], 16'h005A);
      rdy[0] = 1'b0;
      send_bits(0, 8'h81);
      beat(0, 4'h1); beat(0, 4'h0); beat(0, 4'h1);
      idle(); rst = 1'b1; tick(); rst = 1'b0;
      chk("rst_po", pw[0], 16'h00FF);
      chk("rst_valid", {15'd0, val[0]}, 16'h0000);
`else
      // parity: A5 with good and bad parity bit
      rdy[0] = 1'b1;
      send_bits(0, 8'hA5);
      chk("par_no_valid_at_8", {15'd0, val[0]}, 16'h0000);
      beat(0, 4'h0);
      chk("par_valid_at_9", {15'd0, val[0]}, 16'h0001);
      chk("par_word", pw[0], 16'h00A5);
      chk("par_ok", {15'd0, err[0]}, 16'h0000);
      send_bits(0, 8'hA5);
      beat(0, 4'h1);
      chk("par_bad", {15'd0, err[0]}, 16'h0001);
`endif

      // randomized traffic on all three instances
      idle();
      for (int n = 0; n < 600; n++) begin
         rst = ($urandom_range(0, 199) == 0);
         for (int i = 0; i < 3; i++) begin
            se[i]  = ($urandom_range(0, 3) != 0);
            sin[i] = 4'($urandom);
            clr[i] = ($urandom_range(0, 24) == 0);
            rdy[i] = clr[i] ? 1'b0 : 1'($urandom_range(0, 1));
         end
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
